// File: rtl/fpu_minmax_reduce.sv
// fpu_minmax_reduce: streaming FP32 max/min reduction folding elements through FPU_comparator.
// Define FPU_REDUCE_INDEX_EN to add the winning-element index register and out_index port.
module FPU_comparator (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_mode,
  output logic [31:0] o_res
);
  logic        w_nan;
  logic [31:0] w_ka;
  logic [31:0] w_kb;
  logic        w_b_wins;
  // Map FP32 bit patterns onto an unsigned total order in which -0 sorts below +0
  assign w_ka     = i_a[31] ? ~i_a : {1'b1, i_a[30:0]};
  assign w_kb     = i_b[31] ? ~i_b : {1'b1, i_b[30:0]};
  assign w_nan    = (&i_a[30:23] && |i_a[22:0]) || (&i_b[30:23] && |i_b[22:0]);
  assign w_b_wins = i_mode ? (w_kb > w_ka) : (w_kb < w_ka);
  assign o_res    = w_nan ? 32'hFFC00000 : (w_b_wins ? i_b : i_a);
endmodule

module fpu_minmax_reduce #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [31:0]      out_data,
`ifdef FPU_REDUCE_INDEX_EN
  output logic [LEN_W-1:0] out_index,
`endif
  input  logic             out_ready,
  output logic             busy
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  logic [1:0]       r_state;
  logic             r_mode;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_count;
  logic [31:0]      r_acc;
  logic             w_first;
  logic [31:0]      w_res;
  assign w_first = r_count == '0;
  // The first element is compared with itself so a NaN lead element is canonicalised
  FPU_comparator u_cmp (
    .i_a   (w_first ? in_data : r_acc),
    .i_b   (in_data),
    .i_mode(r_mode),
    .o_res (w_res)
  );
  assign in_ready  = r_state == S_ACCUM;
  assign out_valid = r_state == S_DONE;
  assign busy      = r_state != S_IDLE;
  assign out_data  = r_acc;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_mode  <= 1'b0;
      r_len   <= '0;
      r_count <= '0;
      r_acc   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_mode  <= mode;
          r_len   <= len;
          r_count <= '0;
          if (len == '0) r_acc <= 32'hFFC00000;
          r_state <= (len == '0) ? S_DONE : S_ACCUM;
        end
        S_ACCUM: if (in_valid) begin
          r_acc   <= w_res;
          r_count <= r_count + LEN_W'(1);
          if (r_count == r_len - LEN_W'(1)) r_state <= S_DONE;
        end
        S_DONE: if (out_ready) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
`ifdef FPU_REDUCE_INDEX_EN
  logic [LEN_W-1:0] r_idx;
  assign out_index = r_idx;
  // A tie or a sticky NaN leaves the result equal to acc, so the earlier index is kept
  always_ff @(posedge clk) begin
    if (rst) r_idx <= '0;
    else if (r_state == S_IDLE && start && len == '0) r_idx <= '0;
    else if (r_state == S_ACCUM && in_valid && (w_first || w_res != r_acc)) r_idx <= r_count;
  end
`endif
endmodule

// File: tb/tb_fpu_minmax_reduce.sv
// tb_fpu_minmax_reduce: randomized scoreboard bench for fpu_minmax_reduce with a value-level reference model.
module tb_fpu_minmax_reduce;
  localparam int LW = 8;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic [LW-1:0] len = '0;
  logic          in_valid = 1'b0;
  logic [31:0]   in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [31:0]   out_data;
  logic          out_ready = 1'b0;
  logic          busy;
`ifdef FPU_REDUCE_INDEX_EN
  logic [LW-1:0] out_index;
`endif
  typedef struct {logic [31:0] d; int idx;} exp_t;
  exp_t          q[$];
  exp_t          mon_e;
  int            checks = 0;
  int            failures = 0;
  int            ready_mode = 1;
  logic [31:0]   prev_d = '0;
  bit            stall = 1'b0;
  logic [31:0]   vq[$];
  logic [31:0]   spec_vals[10] = '{32'h00000000, 32'h80000000, 32'h3F800000, 32'hBF800000,
                                   32'h7F800000, 32'hFF800000, 32'h7FC00001, 32'h7F800001,
                                   32'h00000001, 32'h80000001};

  fpu_minmax_reduce #(.LEN_W(LW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mode     (mode),
    .len      (len),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
`ifdef FPU_REDUCE_INDEX_EN
    .out_index(out_index),
`endif
    .out_ready(out_ready),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic bit is_nan(input logic [31:0] x);
    return x[30:23] == 8'hFF && x[22:0] != 0;
  endfunction

  function automatic bit lt(input logic [31:0] a, input logic [31:0] b);
    if (a[31] != b[31]) return a[31];
    return a[31] ? (a[30:0] > b[30:0]) : (a[30:0] < b[30:0]);
  endfunction

  // Reduction result: first NaN wins outright, otherwise first occurrence of the extreme value
  function automatic exp_t model(input bit m, input logic [31:0] v[$]);
    exp_t r;
    r.d = 32'hFFC00000;
    r.idx = 0;
    if (v.size() == 0) return r;
    for (int i = 0; i < v.size(); i++)
      if (is_nan(v[i])) begin
        r.idx = i;
        return r;
      end
    r.d = v[0];
    for (int i = 1; i < v.size(); i++)
      if (m ? lt(r.d, v[i]) : lt(v[i], r.d)) begin
        r.d = v[i];
        r.idx = i;
      end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 300) begin
      tick();
      t++;
    end
    if (busy) chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic run_vec(input bit m, input logic [31:0] v[$], input int gap);
    exp_t e;
    e = model(m, v);
    start = 1'b1;
    mode = m;
    len = LW'(v.size());
    q.push_back(e);
    tick();
    start = 1'b0;
    mode = 1'($urandom_range(0, 1));
    len = LW'($urandom);
    for (int i = 0; i < v.size(); i++) begin
      while (gap > 0 && $urandom_range(0, 99) < gap) begin
        in_valid = 1'b0;
        in_data = $urandom;
        tick();
      end
      in_valid = 1'b1;
      in_data = v[i];
      if (!in_ready) begin
        chk("in_ready_accum", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        wait_idle();
        return;
      end
      tick();
    end
    in_valid = 1'b0;
    if (gap == 0) chk("valid_latency", 32'(out_valid), 32'd1);
    wait_idle();
  endtask

  always @(posedge clk) begin
    #2;
    out_ready = (ready_mode == 2) ? ($urandom_range(0, 3) != 0) : ready_mode[0];
  end

  always @(negedge clk) begin
    if (rst) stall = 1'b0;
    else begin
      if (stall) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", out_data, prev_d);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual=%h required=none", out_data);
        end else begin
          mon_e = q.pop_front();
          chk("out_data", out_data, mon_e.d);
`ifdef FPU_REDUCE_INDEX_EN
          chk("out_index", 32'(out_index), 32'(mon_e.idx));
`endif
        end
      end
      stall = out_valid && !out_ready;
      prev_d = out_data;
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_out_data"}, out_data, 32'd0);
`ifdef FPU_REDUCE_INDEX_EN
    chk({tag, "_out_index"}, 32'(out_index), 32'd0);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int r;
    ready_mode = 1;
    repeat (2) tick();
    chk_reset_outputs("reset");
    rst = 1'b0;
    tick();
    vq = '{32'h3F800000, 32'hC0000000, 32'h40400000, 32'h40000000};
    run_vec(1'b1, vq, 0);
    run_vec(1'b0, vq, 0);
    vq = '{32'h3F800000, 32'h7FC00001, 32'h40A00000};
    run_vec(1'b1, vq, 0);
    vq = '{32'h80000000, 32'h00000000};
    run_vec(1'b1, vq, 0);
    vq = '{32'h3F800000, 32'h3F800000};
    run_vec(1'b0, vq, 0);
    vq = '{32'h7F800001, 32'h3F800000};
    run_vec(1'b0, vq, 0);
    // Empty vector held under backpressure, with a start pulse that must be ignored
    ready_mode = 0;
    start = 1'b1;
    len = '0;
    q.push_back('{32'hFFC00000, 0});
    tick();
    start = 1'b0;
    chk("empty_valid", 32'(out_valid), 32'd1);
    chk("empty_data", out_data, 32'hFFC00000);
    for (int i = 0; i < 5; i++) begin
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      start = (i == 2);
      len = LW'(3);
      tick();
    end
    start = 1'b0;
    ready_mode = 1;
    tick();
    tick();
    chk("stall_start_ignored", 32'(busy), 32'd0);
    // Reset part-way through a vector discards it
    ready_mode = 2;
    start = 1'b1;
    mode = 1'b1;
    len = LW'(4);
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    in_data = 32'h40800000;
    tick();
    in_data = 32'h41000000;
    tick();
    in_data = 32'h41800000;
    rst = 1'b1;
    tick();
    in_valid = 1'b0;
    chk_reset_outputs("midrun");
    rst = 1'b0;
    vq = '{32'h40000000, 32'h3F800000};
    run_vec(1'b0, vq, 0);
    for (int k = 0; k < 150; k++) begin
      vq.delete();
      n = ($urandom_range(0, 9) == 0) ? $urandom_range(13, 40) : $urandom_range(0, 12);
      for (int i = 0; i < n; i++) begin
        r = $urandom_range(0, 7);
        if (r == 0 && i > 0) vq.push_back(vq[i-1]);
        else if (r == 1) vq.push_back(spec_vals[$urandom_range(0, 9)]);
        else vq.push_back($urandom);
      end
      run_vec(1'($urandom_range(0, 1)), vq, ($urandom_range(0, 1) == 1) ? 30 : 0);
    end
    tick();
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fpu_minmax_reduce.md
# fpu_minmax_reduce

Streaming FP32 max/min reduction engine that sits directly upstream of the `FPU_comparator` and feeds it every comparison. It accepts a vector of IEEE-754 single-precision elements over a valid/ready stream and folds them pairwise through an instantiated `FPU_comparator`, using the running accumulator as operand A and the new element as operand B. It returns one result per vector over a valid/ready output.

## Interface
- `LEN_W`, default 8: width of the element-count field. The maximum vector length is 2^LEN_W − 1.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a reduction. Sampled only in IDLE.
- `mode` in 1: 1 = fmax, 0 = fmin. Latched on `start`.
- `len` in LEN_W: number of elements in the vector. Latched on `start`.
- `in_valid` in 1: element valid.
- `in_data` in 32: FP32 element.
- `in_ready` out 1: element accepted when `in_valid && in_ready`.
- `out_valid` out 1: result valid.
- `out_data` out 32: reduced result.
- `out_ready` in 1: result consumed when `out_valid && out_ready`.
- `busy` out 1: high in any state other than IDLE.
- `out_index` out LEN_W: zero-based index of the winning element. Present only with `FPU_REDUCE_INDEX_EN`.

## Operation
- FSM states: IDLE, ACCUM, DONE.
- **IDLE**
  - `in_ready`=0, `out_valid`=0.
  - `start`=1 with `len`≠0: latch `mode` and `len`, clear `count`, go to ACCUM.
  - `start`=1 with `len`=0: set `acc`=32'hFFC00000, set index 0, go to DONE.
- **ACCUM**
  - `in_ready`=1 and `out_valid`=0.
  - On each handshake, increment `count` (width LEN_W).
  - First element (`count`==0): `acc` ← comparator(in_data, in_data, mode). This canonicalises a NaN first element to 32'hFFC00000; any other value passes through unchanged.
  - Subsequent elements: `acc` ← comparator(acc, in_data, mode).
  - Handshake with `count`==len−1: go to DONE.
- **DONE**
  - `out_valid`=1, `out_data`=`acc`, `in_ready`=0.
  - On `out_ready`: go to IDLE.
- Comparator semantics, inherited exactly:
  - Any NaN operand yields 32'hFFC00000. Once `acc` is that value, every later step keeps it (NaN is sticky).
  - +0 and −0 are ordered by sign: max(−0,+0) = +0 and min(−0,+0) = −0.
  - Bit-identical operands return A, i.e. the accumulator is kept.
- `start` is ignored whenever the FSM is not in IDLE.
- `mode` and `len` are ignored outside the `start` cycle in IDLE.
- Index rule (with the macro):
  - The index takes the value of `count` on the first element.
  - After that, it updates to `count` only when the comparator result differs from the current `acc`, i.e. the new element strictly wins. Ties keep the earlier index.
  - It freezes at the first NaN element's index.

## Timing
- Accept rate: one element per cycle in ACCUM, with no bubbles.
- The comparator is combinational between the `acc` register / `in_data` and the `acc` D input. There is no pipeline register inside the loop.
- `out_valid` rises the cycle after the final input handshake, or the cycle after `start` when `len`=0.
- Minimum run time: `len`+1 cycles from the `start` edge to `out_valid`, plus one cycle for the output handshake.
- `out_data` and `out_index` hold stable while `out_valid && !out_ready`.
- A new `start` can be accepted in the cycle after the output handshake.
- Reset values, taking effect the cycle after `rst` is sampled high and overriding any handshake in that cycle:
  - state = IDLE
  - `acc` = 0, `count` = 0, index = 0
  - `in_ready`, `out_valid`, `busy` = 0
  - `out_data` = 0, `out_index` = 0
- Reset mid-ACCUM or mid-DONE discards the partial result; no output is produced for that vector.

## Configuration
- `FPU_REDUCE_INDEX_EN` defined: the index register, its update logic and the `out_index` port are compiled in.
- Not defined: none of these exist. `out_data` and all timing are identical in both builds.

## Test plan
- **Basic max:** fmax, len=4, elements 3F800000, C0000000, 40400000, 40000000 → `out_data` 40400000, `out_index` 2, `out_valid` on cycle 5 after `start`.
- **Basic min:** same vector with fmin → `out_data` C0000000, `out_index` 1.
- **NaN sticky:** fmax, len=3, elements 3F800000, 7FC00001, 40A00000 → `out_data` FFC00000, `out_index` 1.
- **Signed zero and ties:** fmax of 80000000, 00000000 → 00000000 with index 1. fmin of 3F800000, 3F800000 → 3F800000 with index 0.
- **Empty vector and backpressure:** `start` with len=0 → `out_valid` next cycle with FFC00000. Holding `out_ready`=0 for 5 cycles keeps `out_data` stable, `in_ready`=0, and a `start` pulse during the stall is ignored.
- **Reset mid-run:** `rst` asserted after 2 of 4 elements → next cycle IDLE with all outputs 0. A fresh fmin run of 40000000, 3F800000 then returns 3F800000.
